// File: rtl/video_timing_ctrl_if.sv
// ---------------------------------------------------------------------------
// video_timing_ctrl_if
// Groups the run request and the raster outputs of the video timing
// controller into one bundle.
//
// Signals:
//   run     consumer -> timing  level request to generate frames
//   hcount  timing -> consumer  current horizontal position
//   vcount  timing -> consumer  current vertical position
//   de      timing -> consumer  position is inside the active area
//   hsync   timing -> consumer  horizontal sync (polarity set by the controller)
//   vsync   timing -> consumer  vertical sync (polarity set by the controller)
//   sof     timing -> consumer  one-cycle pulse at (0,0)
//   eol     timing -> consumer  one-cycle pulse at the last active pixel of a line
//   busy    timing -> consumer  frames are being generated or drained
//
// Modports:
//   master  the timing generator (drives the raster, receives run)
//   slave   a downstream consumer (receives the raster, drives run)
// ---------------------------------------------------------------------------
interface video_timing_ctrl_if #(
    parameter int CW = 8
);
    logic          run;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic          sof;
    logic          eol;
    logic          busy;

    modport master (
        input  run,
        output hcount, vcount, de, hsync, vsync, sof, eol, busy
    );

    modport slave (
        output run,
        input  hcount, vcount, de, hsync, vsync, sof, eol, busy
    );
endinterface

// File: rtl/video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// video_timing_ctrl
// Raster timing generator for the pixel pipeline. Walks hcount/vcount over
// the full H_TOTAL x V_TOTAL raster and decodes data-enable, syncs and the
// frame/line markers. Stopping is frame-granular: once run drops, the
// current frame is always finished before the block goes idle.
//
// Ports:
//   clk    pixel clock, rising edge
//   reset  asynchronous, active-low
//   vif    master side of video_timing_ctrl_if (run in; raster outputs out)
//
// Every output is a flop. The decode is applied to the *next* position so
// that de/syncs/sof/eol always line up with the hcount/vcount presented in
// the same cycle.
// ---------------------------------------------------------------------------
module video_timing_ctrl #(
    parameter int CW       = 8,
    parameter int H_ACTIVE = 16,
    parameter int H_FP     = 2,
    parameter int H_SYNC   = 3,
    parameter int H_BP     = 3,
    parameter int V_ACTIVE = 8,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input logic                 clk,
    input logic                 reset,
    video_timing_ctrl_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] H_EOL      = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          de_q, de_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          busy_q, busy_d;

    logic [CW-1:0] h_adv, v_adv;
    logic          frame_end;

    always_comb begin
        h_adv     = h_q + CW'(1);
        v_adv     = v_q;
        frame_end = (h_q == H_LAST) && (v_q == V_LAST);
        if (h_q == H_LAST) begin
            h_adv = '0;
            v_adv = (v_q == V_LAST) ? '0 : v_q + CW'(1);
        end

        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;

        case (state_q)
            IDLE: begin
                if (vif.run) begin
                    state_d = RUN;
                end
                h_d = '0;
                v_d = '0;
            end
            RUN: begin
                h_d = h_adv;
                v_d = v_adv;
                if (!vif.run) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Re-asserting run mid-drain just resumes the same raster.
                if (vif.run) begin
                    state_d = RUN;
                    h_d     = h_adv;
                    v_d     = v_adv;
                end else if (frame_end) begin
                    state_d = IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end else begin
                    h_d = h_adv;
                    v_d = v_adv;
                end
            end
            default: begin
                state_d = IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase

        // Decode from the next position so the registered strobes match
        // the registered counters.
        busy_d  = (state_d != IDLE);
        de_d    = busy_d && (h_d < H_ACT) && (v_d < V_ACT);
        sof_d   = busy_d && (h_d == '0) && (v_d == '0);
        eol_d   = busy_d && (h_d == H_EOL) && (v_d < V_ACT);
        hsync_d = (busy_d && (h_d >= HS_START) && (h_d < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (busy_d && (v_d >= VS_START) && (v_d < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            busy_q  <= busy_d;
        end
    end

    assign vif.hcount = h_q;
    assign vif.vcount = v_q;
    assign vif.de     = de_q;
    assign vif.hsync  = hsync_q;
    assign vif.vsync  = vsync_q;
    assign vif.sof    = sof_q;
    assign vif.eol    = eol_q;
    assign vif.busy   = busy_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_video_timing_ctrl
// Self-checking bench for video_timing_ctrl with default parameters
// (24 x 12 raster, active-low syncs). A start-up vector table is compared
// directly; every cycle is also compared against a raster model through an
// expectation queue, and frame-level statistics are checked explicitly.
// ---------------------------------------------------------------------------
module tb_video_timing_ctrl;

    localparam int HT    = 24;
    localparam int VT    = 12;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] v;
        logic       de;
        logic       hs;
        logic       vs;
        logic       sof;
        logic       eol;
        logic       busy;
    } out_t;

    typedef struct {
        logic run;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    video_timing_ctrl_if #(.CW(8)) vif ();

    video_timing_ctrl #(.CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    always #5 clk = ~clk;

    out_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   cycleNo    = 0;

    // Raster model: 0 idle, 1 run, 2 drain; position kept as a linear index.
    int mState = 0;
    int mP     = 0;

    localparam out_t RESET_OUT = '{h:8'd0, v:8'd0, de:1'b0, hs:1'b1, vs:1'b1,
                                   sof:1'b0, eol:1'b0, busy:1'b0};

    function automatic out_t modelOut();
        out_t o;
        int   hh;
        int   vv;
        logic b;
        b  = (mState != 0);
        hh = b ? (mP % HT) : 0;
        vv = b ? (mP / HT) : 0;
        o.h    = 8'(hh);
        o.v    = 8'(vv);
        o.busy = b;
        o.de   = b && (hh <= 15) && (vv <= 7);
        o.sof  = b && (mP == 0);
        o.eol  = b && (hh == 15) && (vv <= 7);
        o.hs   = !(b && (hh >= 18) && (hh <= 20));
        o.vs   = !(b && (vv >= 9) && (vv <= 10));
        return o;
    endfunction

    function automatic void modelStep(input logic r);
        case (mState)
            0: if (r) begin mState = 1; mP = 0; end
            1: begin mP = (mP + 1) % FRAME; if (!r) mState = 2; end
            default: begin
                if (r) begin
                    mState = 1;
                    mP = (mP + 1) % FRAME;
                end else if (mP == FRAME - 1) begin
                    mState = 0;
                    mP = 0;
                end else begin
                    mP = mP + 1;
                end
            end
        endcase
    endfunction

    function automatic out_t sampleDut();
        out_t a;
        a = '{h:vif.hcount, v:vif.vcount, de:vif.de, hs:vif.hsync, vs:vif.vsync,
              sof:vif.sof, eol:vif.eol, busy:vif.busy};
        return a;
    endfunction

    task automatic compareOut(input string name, input out_t act, input out_t exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s cyc=%0d: got h=%0d v=%0d de=%b hs=%b vs=%b sof=%b eol=%b busy=%b, want h=%0d v=%0d de=%b hs=%b vs=%b sof=%b eol=%b busy=%b",
                     name, cycleNo, act.h, act.v, act.de, act.hs, act.vs, act.sof, act.eol, act.busy,
                     exp.h, exp.v, exp.de, exp.hs, exp.vs, exp.sof, exp.eol, exp.busy);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive run for the next edge, predict its result, then sample after it.
    task automatic applyStimulus(input logic r);
        @(negedge clk);
        vif.run = r;
        modelStep(r);
        expQ.push_back(modelOut());
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic checkOutput(input string name);
        out_t exp;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing to compare, want one entry", name);
        end else begin
            exp = expQ.pop_front();
            compareOut(name, sampleDut(), exp);
        end
    endtask

    task automatic stepCycle(input logic r, input string name);
        applyStimulus(r);
        checkOutput(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   vsLow, deCnt, eolCnt, sofCnt, lastSof, steps, busyLow;

        vecs[0] = '{run:1'b0, exp:'{h:8'd0, v:8'd0, de:1'b0, hs:1'b1, vs:1'b1, sof:1'b0, eol:1'b0, busy:1'b0}};
        vecs[1] = '{run:1'b1, exp:'{h:8'd0, v:8'd0, de:1'b1, hs:1'b1, vs:1'b1, sof:1'b1, eol:1'b0, busy:1'b1}};
        vecs[2] = '{run:1'b1, exp:'{h:8'd1, v:8'd0, de:1'b1, hs:1'b1, vs:1'b1, sof:1'b0, eol:1'b0, busy:1'b1}};
        vecs[3] = '{run:1'b1, exp:'{h:8'd2, v:8'd0, de:1'b1, hs:1'b1, vs:1'b1, sof:1'b0, eol:1'b0, busy:1'b1}};
        vecs[4] = '{run:1'b0, exp:'{h:8'd3, v:8'd0, de:1'b1, hs:1'b1, vs:1'b1, sof:1'b0, eol:1'b0, busy:1'b1}};
        vecs[5] = '{run:1'b1, exp:'{h:8'd4, v:8'd0, de:1'b1, hs:1'b1, vs:1'b1, sof:1'b0, eol:1'b0, busy:1'b1}};

        reset   = 1'b0;
        vif.run = 1'b0;

        // Reset held for three cycles.
        repeat (3) begin
            @(posedge clk);
            #1;
            expQ.push_back(RESET_OUT);
            checkOutput("reset_hold");
        end
        reset = 1'b1;

        // Start-up vectors, compared to the table and the model.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].run);
            checkOutput("start_model");
            compareOut($sformatf("start_vec%0d", i), sampleDut(), vecs[i].exp);
        end

        // Run to the next frame start, then collect one frame of statistics.
        for (int k = 0; k < 400 && mP != 0; k++) stepCycle(1'b1, "run_to_sof");
        lastSof = cycleNo;
        vsLow = 0; deCnt = 0; eolCnt = 0; sofCnt = 0; steps = 0;
        for (int k = 0; k < FRAME; k++) begin
            stepCycle(1'b1, "frame");
            if (!vif.vsync) vsLow++;
            if (vif.de) deCnt++;
            if (vif.eol) eolCnt++;
            if (vif.sof) begin
                sofCnt++;
                steps = cycleNo - lastSof;
            end
        end
        checkValue("vsync_low_cycles", vsLow, 48);
        checkValue("de_cycles", deCnt, 128);
        checkValue("eol_count", eolCnt, 8);
        checkValue("sof_count", sofCnt, 1);
        checkValue("sof_period", steps, FRAME);

        // Graceful stop: drop run at (5,3).
        for (int k = 0; k < 400 && mP != 3 * HT + 5; k++) stepCycle(1'b1, "run_to_stop");
        steps = 0;
        for (int k = 0; k < 400; k++) begin
            stepCycle(1'b0, "drain");
            steps++;
            if (!vif.busy) break;
        end
        checkValue("drain_length", steps, FRAME - (3 * HT + 5));
        sofCnt = 0;
        for (int k = 0; k < 20; k++) begin
            stepCycle(1'b0, "idle_after_stop");
            if (vif.sof) sofCnt++;
        end
        checkValue("sof_after_stop", sofCnt, 0);

        // Drain interrupted by run at (10,6): raster must not restart.
        stepCycle(1'b1, "rerun_start");
        lastSof = cycleNo;
        busyLow = 0;
        for (int k = 0; k < 400 && mP != 3 * HT + 5; k++) stepCycle(1'b1, "rerun_a");
        for (int k = 0; k < 400 && mP != 6 * HT + 10; k++) begin
            stepCycle(1'b0, "rerun_drain");
            if (!vif.busy) busyLow++;
        end
        steps = -1;
        for (int k = 0; k < 400; k++) begin
            stepCycle(1'b1, "rerun_b");
            if (!vif.busy) busyLow++;
            if (vif.sof) begin
                steps = cycleNo - lastSof;
                break;
            end
        end
        checkValue("rerun_sof_period", steps, FRAME);
        checkValue("rerun_busy_low", busyLow, 0);

        // Asynchronous reset between edges at (7,2).
        for (int k = 0; k < 400 && mP != 2 * HT + 7; k++) stepCycle(1'b1, "run_to_areset");
        #2;
        reset = 1'b0;
        #1;
        mState = 0;
        mP     = 0;
        expQ.push_back(RESET_OUT);
        checkOutput("async_reset_now");
        repeat (2) begin
            @(posedge clk);
            #1;
            expQ.push_back(RESET_OUT);
            checkOutput("async_reset_hold");
        end
        reset = 1'b1;
        stepCycle(1'b1, "restart");
        compareOut("restart_origin", sampleDut(),
                   '{h:8'd0, v:8'd0, de:1'b1, hs:1'b1, vs:1'b1, sof:1'b1, eol:1'b0, busy:1'b1});
        for (int k = 0; k < 30; k++) stepCycle(1'b1, "restart_run");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
# video_timing_ctrl

Sequences the horizontal and vertical pixel counters that pace the image-processing pipeline. It generates pixel coordinates, data-enable and sync strobes, and frame/line markers. Run control is frame-granular: a stop request always completes the current frame. It sits between the pixel clock and every downstream stage that needs raster position or sync.

## Interface
- `CW`, 8: width of `hcount`/`vcount`. It must hold `H_TOTAL-1` and `V_TOTAL-1`.
- `H_ACTIVE`, 16: active pixels per line.
- `H_FP`, 2: horizontal front porch, in cycles.
- `H_SYNC`, 3: hsync width, in cycles.
- `H_BP`, 3: horizontal back porch, in cycles. `H_TOTAL` = sum of the four H parameters = 24.
- `V_ACTIVE`, 8: active lines per frame.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 1: vertical back porch, in lines. `V_TOTAL` = sum of the four V parameters = 12.
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync`. 0 means active-low.
- `clk` in 1: pixel clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-low. `reset`=0 resets the block immediately, independent of `clk`.
- `run` in 1: level request to generate frames.
- `hcount` out CW: current horizontal position.
- `vcount` out CW: current vertical position.
- `de` out 1: high when the current position is inside the active area.
- `hsync` out 1: horizontal sync, at level `SYNC_POL` while asserted.
- `vsync` out 1: vertical sync, at level `SYNC_POL` while asserted.
- `sof` out 1: one-cycle pulse at position (0,0).
- `eol` out 1: one-cycle pulse at the last active pixel of each active line.
- `busy` out 1: high in states RUN and DRAIN.

## Operation
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN: when `run`=1.
  - RUN→DRAIN: when `run`=0.
  - DRAIN→RUN: when `run`=1. The raster continues with no gap or restart.
  - DRAIN→IDLE: on the cycle at position (`H_TOTAL-1`, `V_TOTAL-1`) when `run`=0.
  - RUN does not return to IDLE directly.
- Counting in RUN and DRAIN:
  - `hcount` increments by 1 every cycle. At `H_TOTAL-1` it wraps to 0.
  - `vcount` increments only on an h-wrap. At `V_TOTAL-1` it wraps to 0.
  - All count arithmetic is unsigned, CW bits, and never exceeds TOTAL-1.
- Output decode, applied to the current (h,v):
  - `de` = (h < H_ACTIVE) && (v < V_ACTIVE).
  - `hsync` is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - `vsync` is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, across whole lines.
  - `sof` = (h==0 && v==0) while busy.
  - `eol` = (h==H_ACTIVE-1 && v<V_ACTIVE) while busy.
- In IDLE:
  - Counters are held at 0.
  - `de`, `sof`, `eol` and `busy` are 0.
  - Syncs are at the deasserted level (`!SYNC_POL`).
- The frame wrap from (H_TOTAL-1, V_TOTAL-1) while `run`=1 goes straight to (0,0) with `sof`=1. There is no idle cycle between frames.

## Timing
- All outputs are registered and change only on the `clk` edge or on `reset` assertion.
  - `de`, `hsync`, `vsync`, `sof` and `eol` always describe the `hcount`/`vcount` values presented in the same cycle.
- Reset values, applied asynchronously on `reset`=0:
  - State = IDLE.
  - `hcount`=`vcount`=0.
  - `de`=`sof`=`eol`=`busy`=0.
  - `hsync`=`vsync`=`!SYNC_POL`.
- Reset deassertion is taken synchronously. The first possible RUN cycle is the edge after `reset` returns to 1.
- Start latency:
  - `run` is sampled high in IDLE on edge N.
  - At edge N, state becomes RUN with `busy`=1, `hcount`=0, `vcount`=0, `sof`=1 and `de`=1.
  - At edge N+1, `hcount`=1 and `sof`=0.
- Stop behaviour:
  - Deasserting `run` never truncates a frame.
  - After the edge at position (H_TOTAL-1, V_TOTAL-1), `busy`=0 and all outputs hold their IDLE values.
- Reset mid-frame aborts immediately to the reset values. No partial-frame completion.
- A frame is exactly H_TOTAL×V_TOTAL = 288 cycles with the default parameters.

## Test plan
- Reset then start:
  - Stimulus: hold `reset`=0 for 3 cycles, release, assert `run`.
  - Required: during reset `hsync`=`vsync`=1 and all other outputs are 0. On the first RUN cycle `sof`=1, `de`=1 and `hcount`=`vcount`=0. `sof` repeats every 288 cycles.
- Line timing:
  - Stimulus: observe line 0.
  - Required: `de`=1 for `hcount` 0..15. `eol`=1 only at `hcount`=15. `hsync`=0 for `hcount` 18..20. `hcount` wraps 23→0 and `vcount` goes 0→1 on the same edge.
- Frame timing:
  - Required: `vsync`=0 for all of lines 9 and 10 (48 cycles).
  - Required: `de`=0 and `eol`=0 for `vcount` 8..11.
  - Required: `vcount` wraps 11→0 together with `sof`=1.
- Graceful stop:
  - Stimulus: drop `run` at (5,3).
  - Required: counting continues to (23,11). On the next edge `busy`=0 and the counters are 0,0, with no further `sof`.
- DRAIN re-run:
  - Stimulus: drop `run` at (5,3), re-assert at (10,6).
  - Required: the raster is uninterrupted, `busy` stays 1, and the next `sof` arrives exactly 288 cycles after the previous one.
- Asynchronous reset mid-frame:
  - Stimulus: assert `reset`=0 between edges at (7,2).
  - Required: outputs immediately take the reset values. After release with `run`=1, restart at (0,0) with `sof`=1.
